// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register map,
// TIMER_CTRL bit positions, reset values and the timer write-port payload.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [7:0] OFF_CYCLE       = 8'h00;
  localparam logic [7:0] OFF_TIMER_CMP   = 8'h04;
  localparam logic [7:0] OFF_TIMER_CTRL  = 8'h08;
  localparam logic [7:0] OFF_GPIO        = 8'h0C;
  localparam logic [7:0] OFF_TIMER_COUNT = 8'h10;
  localparam logic [7:0] OFF_LAST        = OFF_TIMER_COUNT;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_PEND_BIT = 1;

  localparam logic [DATA_W-1:0] CYCLE_RST     = '0;
  localparam logic [DATA_W-1:0] GPIO_RST      = '0;
  localparam logic [DATA_W-1:0] TIMER_CNT_RST = '0;
  localparam logic [DATA_W-1:0] TIMER_CMP_RST = '0;

  typedef enum logic [1:0] {
    TIMER_IDLE     = 2'd0,
    TIMER_COUNTING = 2'd1,
    TIMER_MATCH    = 2'd2
  } timer_state_e;

  typedef struct packed {
    logic              cmp_we;
    logic              ctrl_we;
    logic [DATA_W-1:0] wdata;
  } timer_wr_t;

endpackage

// File: rtl/data_mem_responder_timer_unit.sv
// Compare timer: TIMER_COUNT / TIMER_CMP / EN / PEND with a registered match state.
module timer_unit
  import data_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  timer_wr_t         wr,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] cmp_o,
  output logic              en_o,
  output logic              pend_o
);

  timer_state_e      state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              pend_q, pend_d;

  // MATCH is registered from next-cycle values so it equals EN && COUNT==CMP now.
  always_comb begin
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    state_d = state_q;

    if (wr.cmp_we) begin
      cmp_d = wr.wdata;
    end
    if (wr.ctrl_we) begin
      en_d = wr.wdata[CTRL_EN_BIT];
      if (wr.wdata[CTRL_PEND_BIT]) begin
        pend_d = 1'b0;
      end
    end

    case (state_q)
      TIMER_MATCH: begin
        pend_d  = 1'b1;
        count_d = '0;
      end
      TIMER_COUNTING: begin
        count_d = count_q + DATA_W'(1);
      end
      default: begin
      end
    endcase

    if (!en_d) begin
      state_d = TIMER_IDLE;
    end else if (count_d == cmp_d) begin
      state_d = TIMER_MATCH;
    end else begin
      state_d = TIMER_COUNTING;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TIMER_IDLE;
      count_q <= TIMER_CNT_RST;
      cmp_q   <= TIMER_CMP_RST;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  assign count_o = count_q;
  assign cmp_o   = cmp_q;
  assign en_o    = en_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: address decode, word RAM, MMIO block (cycle counter,
// compare timer, GPIO) and a sticky access-fault flag. Reads are combinational.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] data_mem_address,
  input  logic              data_mem_read,
  input  logic              data_mem_write,
  input  logic [DATA_W-1:0] data_mem_write_data,
  output logic [DATA_W-1:0] data_mem_read_data,
  output logic [DATA_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              access_fault
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] RAM_BYTES = ADDR_W'(DEPTH_WORDS * 4);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] gpio_q, gpio_d;
  logic              fault_q, fault_d;

  logic              strobe, misaligned, in_ram, in_mmio, bad;
  logic              ok_rd, ok_wr, ram_we;
  logic [ADDR_W-1:0] mmio_off;
  logic [7:0]        off8;
  logic [IDX_W-1:0]  ram_idx;

  timer_wr_t         tmr_wr;
  logic [DATA_W-1:0] tmr_count, tmr_cmp;
  logic              tmr_en, tmr_pend;

  // Decode and bad-access qualification.
  always_comb begin
    strobe     = data_mem_read | data_mem_write;
    misaligned = (data_mem_address[1:0] != 2'b00);
    mmio_off   = data_mem_address - MMIO_BASE;
    off8       = mmio_off[7:0];
    ram_idx    = data_mem_address[IDX_W+1:2];
    in_ram     = (data_mem_address < RAM_BYTES);
    in_mmio    = (data_mem_address >= MMIO_BASE) && (mmio_off <= ADDR_W'(OFF_LAST));
    bad        = strobe && (misaligned || !(in_ram || in_mmio) ||
                            (data_mem_read && data_mem_write));
    ok_rd      = data_mem_read && !bad;
    ok_wr      = data_mem_write && !bad;
    ram_we     = ok_wr && in_ram;

    tmr_wr.cmp_we  = ok_wr && in_mmio && (off8 == OFF_TIMER_CMP);
    tmr_wr.ctrl_we = ok_wr && in_mmio && (off8 == OFF_TIMER_CTRL);
    tmr_wr.wdata   = data_mem_write_data;
  end

  // Zero-latency read mux; counters return their pre-increment value.
  always_comb begin
    data_mem_read_data = '0;
    if (ok_rd) begin
      if (in_ram) begin
        data_mem_read_data = mem[ram_idx];
      end else begin
        case (off8)
          OFF_CYCLE:       data_mem_read_data = cycle_q;
          OFF_TIMER_CMP:   data_mem_read_data = tmr_cmp;
          OFF_TIMER_CTRL:  data_mem_read_data = DATA_W'({tmr_pend, tmr_en});
          OFF_GPIO:        data_mem_read_data = gpio_q;
          OFF_TIMER_COUNT: data_mem_read_data = tmr_count;
          default:         data_mem_read_data = '0;
        endcase
      end
    end
  end

  always_comb begin
    cycle_d = cycle_q + DATA_W'(1);
    gpio_d  = gpio_q;
    fault_d = fault_q | bad;
    if (ok_wr && in_mmio && (off8 == OFF_GPIO)) begin
      gpio_d = data_mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= CYCLE_RST;
      gpio_q  <= GPIO_RST;
      fault_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      gpio_q  <= gpio_d;
      fault_q <= fault_d;
    end
  end

  // RAM contents survive reset; reset only blocks an in-flight write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (ram_we) begin
      mem[ram_idx] <= data_mem_write_data;
    end
  end

  timer_unit u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (tmr_wr),
    .count_o (tmr_count),
    .cmp_o   (tmr_cmp),
    .en_o    (tmr_en),
    .pend_o  (tmr_pend)
  );

  assign gpio_out     = gpio_q;
  assign timer_irq    = tmr_pend;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM, GPIO, timer,
// fault handling, cycle-counter wrap and asynchronous reset.
module tb_data_mem_responder;

  localparam logic [31:0] MB        = 32'h0001_0000;
  localparam logic [31:0] A_CYCLE   = MB + 32'h00;
  localparam logic [31:0] A_CMP     = MB + 32'h04;
  localparam logic [31:0] A_CTRL    = MB + 32'h08;
  localparam logic [31:0] A_GPIO    = MB + 32'h0C;
  localparam logic [31:0] A_COUNT   = MB + 32'h10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_out;
  logic        timer_irq;
  logic        access_fault;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .data_mem_address    (addr),
    .data_mem_read       (rd),
    .data_mem_write      (wr),
    .data_mem_write_data (wdata),
    .data_mem_read_data  (rdata),
    .gpio_out            (gpio_out),
    .timer_irq           (timer_irq),
    .access_fault        (access_fault)
  );

  task automatic cyc_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic cyc_read(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; rd = 1'b1; wr = 1'b0;
    #1 v = rdata;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset_n = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (gpio_out !== 32'h0 || timer_irq !== 1'b0 || access_fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got gpio=%h irq=%b fault=%b want 0/0/0", gpio_out, timer_irq, access_fault);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc_read(A_CYCLE, v);
    vec_cnt++;
    if (v !== 32'd1) begin
      err_cnt++;
      $display("FAIL reset_cycle: got %h want %h", v, 32'd1);
    end
    @(negedge clk);
    addr = 32'h10; #1;
    vec_cnt++;
    if (rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL idle_rdata: got %h want 0", rdata);
    end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    cyc_write(32'h14, 32'h0BAD_F00D);
    cyc_write(32'h10, 32'hDEAD_BEEF);
    cyc_read(32'h10, v);
    vec_cnt++;
    if (v !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL ram_rd_10: got %h want %h", v, 32'hDEAD_BEEF);
    end
    cyc_read(32'h14, v);
    vec_cnt++;
    if (v !== 32'h0BAD_F00D) begin
      err_cnt++;
      $display("FAIL ram_rd_14: got %h want %h", v, 32'h0BAD_F00D);
    end
    cyc_write(32'h3FC, 32'h1234_5678);
    cyc_read(32'h3FC, v);
    vec_cnt++;
    if (v !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL ram_last_word: got %h want %h", v, 32'h1234_5678);
    end
  endtask

  task automatic test_gpio();
    logic [31:0] v;
    cyc_write(A_GPIO, 32'h0000_00A5);
    vec_cnt++;
    if (gpio_out !== 32'hA5) begin
      err_cnt++;
      $display("FAIL gpio_out: got %h want %h", gpio_out, 32'hA5);
    end
    cyc_read(A_GPIO, v);
    vec_cnt++;
    if (v !== 32'hA5) begin
      err_cnt++;
      $display("FAIL gpio_rd: got %h want %h", v, 32'hA5);
    end
    cyc_write(A_COUNT, 32'h77);
    cyc_write(A_CYCLE, 32'h1234);
    cyc_read(A_COUNT, v);
    vec_cnt++;
    if (v !== 32'h0 || access_fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL ro_write: got count=%h fault=%b want 0/0", v, access_fault);
    end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    cyc_write(A_CMP, 32'd3);
    cyc_write(A_CTRL, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      vec_cnt++;
      if (timer_irq !== 1'b0) begin
        err_cnt++;
        $display("FAIL irq_early_%0d: got %b want 0", i, timer_irq);
      end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (timer_irq !== 1'b1) begin
      err_cnt++;
      $display("FAIL irq_rise: got %b want 1", timer_irq);
    end
    cyc_read(A_COUNT, v);
    vec_cnt++;
    if (v !== 32'd0) begin
      err_cnt++;
      $display("FAIL count_after_match: got %h want 0", v);
    end
    cyc_read(A_CTRL, v);
    vec_cnt++;
    if (v !== 32'h3) begin
      err_cnt++;
      $display("FAIL ctrl_rd: got %h want 3", v);
    end
    cyc_write(A_CTRL, 32'h2);
    vec_cnt++;
    if (timer_irq !== 1'b0) begin
      err_cnt++;
      $display("FAIL irq_w1c: got %b want 0", timer_irq);
    end
    cyc_read(A_COUNT, v);
    vec_cnt++;
    if (v !== 32'd3) begin
      err_cnt++;
      $display("FAIL count_frozen_a: got %h want 3", v);
    end
    repeat (2) @(posedge clk);
    cyc_read(A_COUNT, v);
    vec_cnt++;
    if (v !== 32'd3) begin
      err_cnt++;
      $display("FAIL count_frozen_b: got %h want 3", v);
    end
    // Re-enable with COUNT==CMP: match cycle, CMP written there uses old value.
    cyc_write(A_CTRL, 32'h1);
    cyc_write(A_CMP, 32'd5);
    vec_cnt++;
    if (timer_irq !== 1'b1) begin
      err_cnt++;
      $display("FAIL cmp_write_on_match: got irq %b want 1", timer_irq);
    end
    cyc_read(A_COUNT, v);
    vec_cnt++;
    if (v !== 32'd0) begin
      err_cnt++;
      $display("FAIL count_reload: got %h want 0", v);
    end
    repeat (4) @(posedge clk);
    cyc_write(A_CTRL, 32'h3);
    vec_cnt++;
    if (timer_irq !== 1'b1) begin
      err_cnt++;
      $display("FAIL pend_set_wins: got %b want 1", timer_irq);
    end
    cyc_write(A_CTRL, 32'h3);
    vec_cnt++;
    if (timer_irq !== 1'b0) begin
      err_cnt++;
      $display("FAIL pend_clear: got %b want 0", timer_irq);
    end
    cyc_write(A_CTRL, 32'h0);
  endtask

  task automatic test_fault();
    logic [31:0] v;
    cyc_read(32'h0000_0002, v);
    vec_cnt++;
    if (v !== 32'h0 || access_fault !== 1'b1) begin
      err_cnt++;
      $display("FAIL misaligned_rd: got data=%h fault=%b want 0/1", v, access_fault);
    end
    cyc_write(32'h0002_0000, 32'hFFFF_FFFF);
    cyc_write(MB + 32'h0E, 32'h0);
    vec_cnt++;
    if (gpio_out !== 32'hA5 || access_fault !== 1'b1) begin
      err_cnt++;
      $display("FAIL unmapped_wr: got gpio=%h fault=%b want a5/1", gpio_out, access_fault);
    end
    cyc_read(MB + 32'h14, v);
    vec_cnt++;
    if (v !== 32'h0) begin
      err_cnt++;
      $display("FAIL mmio_hole_rd: got %h want 0", v);
    end
    @(negedge clk);
    addr = 32'h10; rd = 1'b1; wr = 1'b1; wdata = 32'h55;
    #1;
    vec_cnt++;
    if (rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL rdwr_data: got %h want 0", rdata);
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    cyc_read(32'h10, v);
    vec_cnt++;
    if (v !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL rdwr_suppressed: got %h want %h", v, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_cycle_wrap();
    logic [31:0] v;
    logic [31:0] exp_v [3];
    exp_v[0] = 32'hFFFF_FFFE; exp_v[1] = 32'hFFFF_FFFF; exp_v[2] = 32'h0;
    @(posedge clk); #1;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    for (int i = 0; i < 3; i++) begin
      cyc_read(A_CYCLE, v);
      vec_cnt++;
      if (v !== exp_v[i]) begin
        err_cnt++;
        $display("FAIL cycle_wrap_%0d: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] v;
    cyc_write(A_CMP, 32'd3);
    cyc_write(A_CTRL, 32'h1);
    repeat (2) @(posedge clk); #1;
    vec_cnt++;
    if (timer_irq !== 1'b1 || access_fault !== 1'b1 || gpio_out !== 32'hA5) begin
      err_cnt++;
      $display("FAIL pre_reset: got irq=%b fault=%b gpio=%h want 1/1/a5", timer_irq, access_fault, gpio_out);
    end
    @(negedge clk);
    addr = 32'h14; wdata = 32'h1234_5678; wr = 1'b1; rd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++;
    if (gpio_out !== 32'h0 || timer_irq !== 1'b0 || access_fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: got gpio=%h irq=%b fault=%b want 0/0/0", gpio_out, timer_irq, access_fault);
    end
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc_read(A_CYCLE, v);
    vec_cnt++;
    if (v !== 32'd1) begin
      err_cnt++;
      $display("FAIL post_reset_cycle: got %h want 1", v);
    end
    cyc_read(32'h14, v);
    vec_cnt++;
    if (v !== 32'h0BAD_F00D) begin
      err_cnt++;
      $display("FAIL aborted_write: got %h want %h", v, 32'h0BAD_F00D);
    end
    cyc_read(A_CTRL, v);
    vec_cnt++;
    if (v !== 32'h0) begin
      err_cnt++;
      $display("FAIL post_reset_ctrl: got %h want 0", v);
    end
    cyc_read(A_CMP, v);
    vec_cnt++;
    if (v !== 32'h0) begin
      err_cnt++;
      $display("FAIL post_reset_cmp: got %h want 0", v);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_fault();
    test_cycle_wrap();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the core's data-memory interface: accepts the single-cycle core's address/read/write strobes and returns read data in the same cycle. Decodes a word-addressed RAM region and a small MMIO region holding a free-running cycle counter, a compare timer with interrupt, and a GPIO output register. Sits beside the core top-level and is driven directly by its data-memory outputs.

## Interface
Parameters:
- DEPTH_WORDS, 256, RAM size in 32-bit words; RAM occupies bytes 0 .. DEPTH_WORDS*4-1.
- MMIO_BASE, 32'h0001_0000, base byte address of the MMIO register block.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_mem_address  input  32  byte address from core.
- data_mem_read  input  1  read strobe.
- data_mem_write  input  1  write strobe.
- data_mem_write_data  input  32  store data.
- data_mem_read_data  output  32  load data, combinational.
- gpio_out  output  32  GPIO register value.
- timer_irq  output  1  timer interrupt pending.
- access_fault  output  1  sticky bad-access flag.

## Operation
- Word accesses only; byte address bits [1:0] must be 0.
- Decode: RAM if address < DEPTH_WORDS*4; MMIO if address in MMIO_BASE+0x00..0x10; all else unmapped.
- MMIO map (offset from MMIO_BASE): 0x00 CYCLE (RO), 0x04 TIMER_CMP (RW), 0x08 TIMER_CTRL (bit0 EN RW, bit1 PEND W1C, others read 0), 0x0C GPIO (RW), 0x10 TIMER_COUNT (RO).
- Writes to RO registers: ignored, no fault.
- Bad access = strobe active and (misaligned, or unmapped, or read and write both high). Effect: write suppressed, read data 0, access_fault set; stays set until reset.
- No strobe active: data_mem_read_data = 0, no state change except counters.
- CYCLE: increments every cycle, wraps 32'hFFFF_FFFF -> 0.
- Timer: when EN=1, TIMER_COUNT increments each cycle; when EN=1 and TIMER_COUNT == TIMER_CMP, next edge sets PEND and loads TIMER_COUNT with 0. EN=0 freezes TIMER_COUNT; writing EN=0 does not clear count.
- timer_irq = PEND.
- Timer state: IDLE (EN=0), COUNTING (EN=1, no match), MATCH (compare true this cycle, returns to COUNTING next edge).

## Timing
- Reads: zero latency; data_mem_read_data combinational from address in the same cycle.
- Writes: take effect at the rising edge ending the strobe cycle.
- Read/write same address same cycle: disallowed (fault); read of an address in the cycle after a write returns new data.
- CYCLE/TIMER_COUNT reads return the value before this cycle's increment.
- PEND set by match and W1C clear on the same edge: set wins.
- Write to TIMER_CMP on a match cycle: match evaluated against old TIMER_CMP.
- Reset (async, any time): CYCLE, TIMER_COUNT, TIMER_CMP, TIMER_CTRL, GPIO = 0; gpio_out = 0, timer_irq = 0, access_fault = 0 immediately. RAM contents not reset (undefined). Reset asserted mid-strobe aborts the write.

## Structure
- Shared package: MMIO offsets, TIMER_CTRL bit indices (EN=0, PEND=1), reset constants.
- One sub-module: timer_unit (TIMER_COUNT, TIMER_CMP, EN, PEND, compare logic, irq); decode, RAM, CYCLE, GPIO, fault in the top.

## Test plan
- Reset, write 32'hDEAD_BEEF to 0x0000_0010, read 0x10 next cycle -> 32'hDEAD_BEEF; address 0x14 unchanged.
- Write GPIO (MMIO_BASE+0x0C) with 32'h0000_00A5 -> gpio_out = 32'hA5 one edge later; read back returns 32'hA5.
- TIMER_CMP=3, EN=1 -> PEND and timer_irq rise 4 cycles after EN write edge; TIMER_COUNT reads 0 next cycle; write 32'h2 to TIMER_CTRL (EN=0, PEND cleared) -> timer_irq = 0, TIMER_COUNT frozen.
- Read 0x0000_0002 (misaligned) -> read data 0, access_fault = 1 and held; write to 0x0002_0000 (unmapped) -> no state change.
- Force CYCLE near 32'hFFFF_FFFE (hierarchical deposit) -> reads FFFF_FFFE, FFFF_FFFF, 0 on consecutive cycles.
- Assert reset_n low mid-write with timer running and fault set -> all outputs 0 asynchronously, write not committed.
